// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_pkg
//  Description : Shared encodings for the alarm-time writer: FSM state codes,
//                display set-mode codes and BCD wrap limits.
//  Revision    : 1.0  initial release
// ============================================================================
package alarm_pkg;

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t c_st_idle    = 3'd0;
    localparam state_t c_st_set_hr  = 3'd1;
    localparam state_t c_st_set_min = 3'd2;
    localparam state_t c_st_ring    = 3'd3;
    localparam state_t c_st_snooze  = 3'd4;

    // set_mode output codes (drive the display blink)
    typedef logic [1:0] set_mode_t;
    localparam set_mode_t c_mode_normal  = 2'b00;
    localparam set_mode_t c_mode_set_hr  = 2'b01;
    localparam set_mode_t c_mode_set_min = 2'b10;

    // BCD wrap limits
    localparam logic [7:0] HR_MAX  = 8'h23;
    localparam logic [7:0] MIN_MAX = 8'h59;

endpackage
`default_nettype wire

// File: rtl/alarm_set_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_set_ctrl_if
//  Description : Alarm-time link between the key-driven writer and the alarm
//                comparator: BCD alarm time one way, match flag the other.
//  Revision    : 1.0  initial release
// ============================================================================
interface alarm_set_ctrl_if;

    logic [7:0] Set_Hr;
    logic [7:0] Set_Min;
    logic       alarm_match;

    // Writer side (alarm_set_ctrl)
    modport master (
        output Set_Hr,
        output Set_Min,
        input  alarm_match
    );

    // Comparator side
    modport slave (
        input  Set_Hr,
        input  Set_Min,
        output alarm_match
    );

endinterface
`default_nettype wire

// File: rtl/bcd_wrap_inc.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_wrap_inc
//  Description : Combinational two-digit BCD increment that wraps to 00 when
//                the input equals the supplied maximum.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_wrap_inc (
    input  wire logic [7:0] i_val,
    input  wire logic [7:0] i_max,
    output logic      [7:0] o_nxt
);

    // Wrap at max, carry units digit 9 into the tens digit, else bump units
    always_comb begin
        o_nxt = 8'h00;
        if (i_val == i_max) begin
            o_nxt = 8'h00;
        end else if (i_val[3:0] >= 4'd9) begin
            o_nxt = {i_val[7:4] + 4'd1, 4'h0};
        end else begin
            o_nxt = {i_val[7:4], i_val[3:0] + 4'd1};
        end
    end

endmodule
`default_nettype wire

// File: rtl/alarm_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_set_ctrl
//  Description : Key-driven alarm-time writer. Edits the BCD alarm hour and
//                minute, arms/disarms, rings on a comparator match edge, and
//                handles ring timeout and snooze.
//  Config      : ALARM_BEEP_PATTERN_EN - when defined, the bell output
//                toggles every sec_tick while ringing instead of staying on.
//  Revision    : 1.0  initial release
// ============================================================================
module alarm_set_ctrl
    import alarm_pkg::*;
#(
    parameter logic [7:0] DEF_HR      = 8'h07,
    parameter logic [7:0] DEF_MIN     = 8'h00,
    parameter int         RING_SECS   = 60,
    parameter int         SNOOZE_SECS = 300
) (
    input  wire logic          CP,
    input  wire logic          CR,
    input  wire logic          sec_tick,
    input  wire logic          key_mode,
    input  wire logic          key_inc,
    input  wire logic          key_arm,
    alarm_set_ctrl_if.master   alm,
    output logic [1:0]         set_mode,
    output logic               armed,
    output logic               ringing
);

    localparam int RING_W = $clog2(RING_SECS + 1);
    localparam int SNZ_W  = $clog2(SNOOZE_SECS + 1);

    localparam logic [RING_W-1:0] c_ring_last = RING_W'(RING_SECS - 1);
    localparam logic [RING_W-1:0] c_ring_one  = RING_W'(1);
    localparam logic [SNZ_W-1:0]  c_snz_last  = SNZ_W'(SNOOZE_SECS - 1);
    localparam logic [SNZ_W-1:0]  c_snz_one   = SNZ_W'(1);

    state_t              state_q,    state_d;
    logic [7:0]          hr_q,       hr_d;
    logic [7:0]          min_q,      min_d;
    logic                armed_q,    armed_d;
    logic                ringing_q,  ringing_d;
    set_mode_t           set_mode_q, set_mode_d;
    logic [RING_W-1:0]   ring_cnt_q, ring_cnt_d;
    logic [SNZ_W-1:0]    snz_cnt_q,  snz_cnt_d;
    logic [3:0]          prev_q,     prev_d;    // {match, arm, mode, inc}

    logic [7:0] hr_nxt;
    logic [7:0] min_nxt;
    logic       arm_rise, mode_rise, inc_rise, match_rise;
    logic       ev_arm, ev_mode, ev_inc;

    bcd_wrap_inc u_hr_inc (
        .i_val (hr_q),
        .i_max (HR_MAX),
        .o_nxt (hr_nxt)
    );

    bcd_wrap_inc u_min_inc (
        .i_val (min_q),
        .i_max (MIN_MAX),
        .o_nxt (min_nxt)
    );

    // Rising-edge detection and key priority arm > mode > inc
    always_comb begin
        prev_d     = {alm.alarm_match, key_arm, key_mode, key_inc};
        inc_rise   = key_inc         & ~prev_q[0];
        mode_rise  = key_mode        & ~prev_q[1];
        arm_rise   = key_arm         & ~prev_q[2];
        match_rise = alm.alarm_match & ~prev_q[3];
        ev_arm     = arm_rise;
        ev_mode    = mode_rise & ~arm_rise;
        ev_inc     = inc_rise  & ~arm_rise & ~mode_rise;
    end

    // State and all registered outputs; reset wins over every other update
    always_ff @(posedge CP) begin
        if (CR) begin
            state_q    <= c_st_idle;
            hr_q       <= DEF_HR;
            min_q      <= DEF_MIN;
            armed_q    <= 1'b0;
            ringing_q  <= 1'b0;
            set_mode_q <= c_mode_normal;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            prev_q     <= '0;
        end else begin
            state_q    <= state_d;
            hr_q       <= hr_d;
            min_q      <= min_d;
            armed_q    <= armed_d;
            ringing_q  <= ringing_d;
            set_mode_q <= set_mode_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            prev_q     <= prev_d;
        end
    end

    // Next state plus the alarm-time / arm edits that key events cause.
    // A key event in a cycle takes precedence over a match or a timeout.
    always_comb begin
        state_d = state_q;
        hr_d    = hr_q;
        min_d   = min_q;
        armed_d = armed_q;
        case (state_q)
            c_st_idle: begin
                if (ev_arm) begin
                    armed_d = ~armed_q;
                end else if (ev_mode) begin
                    state_d = c_st_set_hr;
                end else if (match_rise && armed_q) begin
                    state_d = c_st_ring;
                end
            end
            c_st_set_hr: begin
                if (ev_arm) begin
                    state_d = c_st_idle;
                end else if (ev_mode) begin
                    state_d = c_st_set_min;
                end else if (ev_inc) begin
                    hr_d = hr_nxt;
                end
            end
            c_st_set_min: begin
                if (ev_arm) begin
                    state_d = c_st_idle;
                end else if (ev_mode) begin
                    state_d = c_st_idle;
                    armed_d = 1'b1;
                end else if (ev_inc) begin
                    min_d = min_nxt;
                end
            end
            c_st_ring: begin
                if (ev_arm) begin
                    state_d = c_st_idle;
                    armed_d = 1'b0;
                end else if (ev_inc) begin
                    state_d = c_st_snooze;
                end else if (sec_tick && (ring_cnt_q == c_ring_last)) begin
                    state_d = c_st_idle;
                end
            end
            c_st_snooze: begin
                if (ev_arm) begin
                    state_d = c_st_idle;
                    armed_d = 1'b0;
                end else if (sec_tick && (snz_cnt_q == c_snz_last)) begin
                    state_d = c_st_ring;
                end
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    // Registered outputs and second counters, derived from the next state;
    // counters restart on any state change
    always_comb begin
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        set_mode_d = c_mode_normal;
        ringing_d  = 1'b0;

        if (state_d != state_q) begin
            ring_cnt_d = '0;
            snz_cnt_d  = '0;
        end else if (sec_tick) begin
            if (state_q == c_st_ring)   ring_cnt_d = ring_cnt_q + c_ring_one;
            if (state_q == c_st_snooze) snz_cnt_d  = snz_cnt_q + c_snz_one;
        end

        case (state_d)
            c_st_set_hr:  set_mode_d = c_mode_set_hr;
            c_st_set_min: set_mode_d = c_mode_set_min;
            default:      set_mode_d = c_mode_normal;
        endcase

`ifdef ALARM_BEEP_PATTERN_EN
        if (state_d == c_st_ring) begin
            if (state_q != c_st_ring) begin
                ringing_d = 1'b1;
            end else if (sec_tick) begin
                ringing_d = ~ringing_q;
            end else begin
                ringing_d = ringing_q;
            end
        end
`else
        ringing_d = (state_d == c_st_ring);
`endif
    end

    assign alm.Set_Hr  = hr_q;
    assign alm.Set_Min = min_q;
    assign set_mode    = set_mode_q;
    assign armed       = armed_q;
    assign ringing     = ringing_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_set_ctrl
//  Description : Self-checking bench for alarm_set_ctrl: directed scenarios
//                followed by random key/tick/match traffic, every cycle
//                compared against a behavioural model of the alarm writer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alarm_set_ctrl;

    localparam int RING_S   = 60;
    localparam int SNOOZE_S = 300;

    logic       CP;
    logic       r_cr, r_tick, r_mode, r_inc, r_arm, r_match;
    logic [1:0] w_set_mode;
    logic       w_armed, w_ringing;

    int n_cmp;
    int n_bad;

    alarm_set_ctrl_if ifc ();
    assign ifc.alarm_match = r_match;

    alarm_set_ctrl dut (
        .CP       (CP),
        .CR       (r_cr),
        .sec_tick (r_tick),
        .key_mode (r_mode),
        .key_inc  (r_inc),
        .key_arm  (r_arm),
        .alm      (ifc),
        .set_mode (w_set_mode),
        .armed    (w_armed),
        .ringing  (w_ringing)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    // ---------------- behavioural model ----------------
    // activity: 0 normal, 1 editing hour, 2 editing minute, 3 bell, 4 snoozing
    int m_act;
    int m_hr, m_min, m_secs;
    bit m_armed, m_bell;
    bit p_mode, p_inc, p_arm, p_match;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic model_step();
        bit e_arm, e_mode, e_inc, e_match;
        int prev_act;
        if (r_cr) begin
            m_act = 0; m_hr = 7; m_min = 0; m_secs = 0;
            m_armed = 0; m_bell = 0;
            p_mode = 0; p_inc = 0; p_arm = 0; p_match = 0;
            return;
        end
        e_arm   = r_arm   && !p_arm;
        e_mode  = r_mode  && !p_mode && !e_arm;
        e_inc   = r_inc   && !p_inc  && !(r_arm && !p_arm) && !(r_mode && !p_mode);
        e_match = r_match && !p_match;
        p_arm = r_arm; p_mode = r_mode; p_inc = r_inc; p_match = r_match;
        prev_act = m_act;
        if (m_act == 0) begin
            if (e_arm) m_armed = !m_armed;
            else if (e_mode) m_act = 1;
            else if (e_match && m_armed) m_act = 3;
        end else if (m_act == 1) begin
            if (e_arm) m_act = 0;
            else if (e_mode) m_act = 2;
            else if (e_inc) m_hr = (m_hr + 1) % 24;
        end else if (m_act == 2) begin
            if (e_arm) m_act = 0;
            else if (e_mode) begin m_act = 0; m_armed = 1; end
            else if (e_inc) m_min = (m_min + 1) % 60;
        end else if (m_act == 3) begin
            if (e_arm) begin m_act = 0; m_armed = 0; end
            else if (e_inc) m_act = 4;
            else if (r_tick) begin
                m_secs++;
                if (m_secs >= RING_S) m_act = 0;
            end
        end else begin
            if (e_arm) begin m_act = 0; m_armed = 0; end
            else if (r_tick) begin
                m_secs++;
                if (m_secs >= SNOOZE_S) m_act = 3;
            end
        end
        if (m_act != prev_act) begin
            m_secs = 0;
            m_bell = (m_act == 3);
        end else if (m_act == 3 && r_tick) begin
`ifdef ALARM_BEEP_PATTERN_EN
            m_bell = !m_bell;
`else
            m_bell = 1;
`endif
        end
    endtask

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: apply current inputs, advance model, compare all outputs
    task automatic step();
        @(posedge CP);
        #1;
        model_step();
        check_val("Set_Hr",   32'(ifc.Set_Hr),  32'(to_bcd(m_hr)));
        check_val("Set_Min",  32'(ifc.Set_Min), 32'(to_bcd(m_min)));
        check_val("set_mode", 32'(w_set_mode),  32'((m_act == 1) ? 1 : (m_act == 2) ? 2 : 0));
        check_val("armed",    32'(w_armed),     32'(m_armed));
        check_val("ringing",  32'(w_ringing),   32'(m_bell));
        r_tick = 1'b0;
    endtask

    // key: 0 mode, 1 inc, 2 arm
    task automatic press(input int key);
        if (key == 0) r_mode = 1'b1; else if (key == 1) r_inc = 1'b1; else r_arm = 1'b1;
        step();
        r_mode = 1'b0; r_inc = 1'b0; r_arm = 1'b0;
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            r_tick = 1'b1;
            step();
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        r_cr = 1'b1; r_tick = 0; r_mode = 0; r_inc = 0; r_arm = 0; r_match = 0;

        // reset state
        step();
        check_val("rst_hr",   32'(ifc.Set_Hr),  32'h07);
        check_val("rst_min",  32'(ifc.Set_Min), 32'h00);
        check_val("rst_mode", 32'(w_set_mode),  32'h0);
        check_val("rst_arm",  32'(w_armed),     32'h0);
        check_val("rst_ring", 32'(w_ringing),   32'h0);
        r_cr = 1'b0;
        step();

        // hour editing with BCD carry and 23 -> 00 wrap
        press(0);
        check_val("mode_hr", 32'(w_set_mode), 32'h1);
        for (int i = 1; i <= 17; i++) begin
            press(1);
            if (i == 2)  check_val("hr_09", 32'(ifc.Set_Hr), 32'h09);
            if (i == 3)  check_val("hr_10", 32'(ifc.Set_Hr), 32'h10);
            if (i == 16) check_val("hr_23", 32'(ifc.Set_Hr), 32'h23);
        end
        check_val("hr_wrap", 32'(ifc.Set_Hr), 32'h00);

        // minute editing, full wrap back to 00, exit arms
        press(0);
        check_val("mode_min", 32'(w_set_mode), 32'h2);
        for (int i = 1; i <= 60; i++) begin
            press(1);
            if (i == 59) check_val("min_59", 32'(ifc.Set_Min), 32'h59);
        end
        check_val("min_wrap", 32'(ifc.Set_Min), 32'h00);
        press(0);
        check_val("exit_mode", 32'(w_set_mode), 32'h0);
        check_val("exit_arm",  32'(w_armed),    32'h1);

        // ring on match edge, timeout, held match does not retrigger
        r_match = 1'b1;
        step();
        check_val("ring_on", 32'(w_ringing), 32'h1);
        ticks(RING_S);
        check_val("ring_tmo", 32'(w_ringing), 32'h0);
        for (int i = 0; i < 5; i++) step();
        check_val("no_rering", 32'(w_ringing), 32'h0);

        // snooze and re-ring, then stop with arm
        r_match = 1'b0; step();
        r_match = 1'b1; step();
        check_val("ring2_on", 32'(w_ringing), 32'h1);
        press(1);
        check_val("snooze_off", 32'(w_ringing), 32'h0);
        ticks(SNOOZE_S);
        check_val("snooze_rering", 32'(w_ringing), 32'h1);
        press(2);
        check_val("stop_arm",  32'(w_armed),   32'h0);
        check_val("stop_ring", 32'(w_ringing), 32'h0);

        // simultaneous arm + inc in ring: stop wins, held keys do not repeat
        press(2);
        r_match = 1'b0; step();
        r_match = 1'b1; step();
        check_val("ring3_on", 32'(w_ringing), 32'h1);
        r_arm = 1'b1; r_inc = 1'b1;
        step();
        check_val("both_arm",  32'(w_armed),   32'h0);
        check_val("both_ring", 32'(w_ringing), 32'h0);
        for (int i = 0; i < 4; i++) step();
        check_val("held_arm", 32'(w_armed), 32'h0);
        r_arm = 1'b0; r_inc = 1'b0;
        step();

        // reset during minute edit restores defaults
        press(0); press(1); press(0); press(1); press(1);
        r_cr = 1'b1;
        step();
        check_val("rst2_hr",   32'(ifc.Set_Hr),  32'h07);
        check_val("rst2_min",  32'(ifc.Set_Min), 32'h00);
        check_val("rst2_mode", 32'(w_set_mode),  32'h0);
        r_cr = 1'b0;
        r_match = 1'b0;
        step();

        // random traffic against the model
        for (int i = 0; i < 6000; i++) begin
            r_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7)  == 0) r_mode  = ~r_mode;
            if ($urandom_range(0, 5)  == 0) r_inc   = ~r_inc;
            if ($urandom_range(0, 9)  == 0) r_arm   = ~r_arm;
            if ($urandom_range(0, 29) == 0) r_match = ~r_match;
            r_cr = ($urandom_range(0, 1499) == 0);
            step();
        end
        r_cr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
